// File: rtl/usbh_tx_seq.sv
// usbh_tx_seq: pops one transfer's worth of host FIFO bytes onto the SIE TX valid/accept stream
module usbh_tx_seq #(
    parameter int LEN_W     = 16,
    parameter int TIMEOUT   = 255,
    parameter int TIMEOUT_W = 8
) (
    input  logic             clk_i,
    input  logic             n_rst_i,
    input  logic             start_i,
    input  logic [LEN_W-1:0] len_i,
    input  logic             abort_i,
    input  logic             fifo_empty_i,
    input  logic [7:0]       fifo_data_i,
    output logic             fifo_pop_o,
    output logic             fifo_flush_o,
    output logic             tx_valid_o,
    output logic [7:0]       tx_data_o,
    output logic             tx_last_o,
    input  logic             tx_accept_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             underrun_o,
    output logic [LEN_W-1:0] remaining_o
);
    typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;

    state_t               state_q, state_d;
    logic [LEN_W-1:0]     rem_q, rem_d;
    logic [TIMEOUT_W-1:0] wait_q, wait_d;
    logic [7:0]           data_q, data_d;
    logic                 valid_q, valid_d, last_q, last_d;
    logic                 done_q, done_d, under_q, under_d, flush_q, flush_d;
    logic                 fetch;

    // A fetch both pops the FIFO and reloads the output byte, from LOAD or straight out of SEND
    assign fetch = !abort_i && !fifo_empty_i &&
                   (state_q == LOAD || (state_q == SEND && tx_accept_i && !last_q));

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        wait_d  = wait_q;
        data_d  = data_q;
        valid_d = valid_q;
        last_d  = last_q;
        done_d  = 1'b0;
        under_d = 1'b0;
        flush_d = 1'b0;
        if (abort_i) begin
            state_d = IDLE;
            rem_d   = '0;
            wait_d  = '0;
            valid_d = 1'b0;
            last_d  = 1'b0;
            flush_d = 1'b1;
        end else if (fetch) begin
            state_d = SEND;
            data_d  = fifo_data_i;
            valid_d = 1'b1;
            last_d  = (rem_q == LEN_W'(1));
            rem_d   = rem_q - LEN_W'(1);
            wait_d  = '0;
        end else if (state_q == LOAD) begin
            if (wait_q == TIMEOUT_W'(TIMEOUT - 1)) begin
                state_d = IDLE;
                rem_d   = '0;
                wait_d  = '0;
                under_d = 1'b1;
                flush_d = 1'b1;
            end else begin
                wait_d = wait_q + 1'b1;
            end
        end else if (state_q == SEND && tx_accept_i) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            done_d  = last_q;
            wait_d  = '0;
            state_d = last_q ? IDLE : LOAD;
        end else if (state_q == IDLE && start_i) begin
            done_d  = (len_i == '0);
            rem_d   = len_i;
            wait_d  = '0;
            state_d = (len_i == '0) ? IDLE : LOAD;
        end
    end

    always_ff @(posedge clk_i or negedge n_rst_i) begin
        if (!n_rst_i) begin
            state_q <= IDLE;
            rem_q   <= '0;
            wait_q  <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            under_q <= 1'b0;
            flush_q <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            wait_q  <= wait_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            done_q  <= done_d;
            under_q <= under_d;
            flush_q <= flush_d;
        end
    end

    assign fifo_pop_o   = fetch;
    assign fifo_flush_o = flush_q;
    assign tx_valid_o   = valid_q;
    assign tx_data_o    = data_q;
    assign tx_last_o    = last_q;
    assign busy_o       = (state_q != IDLE);
    assign done_o       = done_q;
    assign underrun_o   = under_q;
    assign remaining_o  = rem_q;
endmodule

// File: tb/tb_usbh_tx_seq.sv
// tb_usbh_tx_seq: scenario tasks against a queue-level transfer model and a simple FIFO model
module tb_usbh_tx_seq;
    localparam int LEN_W = 8;
    localparam int TO    = 8;
    localparam int TO_W  = 4;

    logic             clk_i = 1'b0;
    logic             n_rst_i = 1'b0;
    logic             start_i = 1'b0;
    logic [LEN_W-1:0] len_i = '0;
    logic             abort_i = 1'b0;
    logic             tx_accept_i = 1'b0;
    logic             fifo_empty_i;
    logic [7:0]       fifo_data_i;
    logic             fifo_pop_o, fifo_flush_o, tx_valid_o, tx_last_o, busy_o, done_o, underrun_o;
    logic [7:0]       tx_data_o;
    logic [LEN_W-1:0] remaining_o;

    int cmp = 0;
    int errs = 0;

    logic [7:0] mem [256];
    int         head = 0;
    int         tail = 0;
    logic [7:0] obs_d [$];
    logic       obs_l [$];
    int         pops = 0, dones = 0, unders = 0, flushes = 0;

    usbh_tx_seq #(.LEN_W(LEN_W), .TIMEOUT(TO), .TIMEOUT_W(TO_W)) dut (
        .clk_i(clk_i), .n_rst_i(n_rst_i), .start_i(start_i), .len_i(len_i), .abort_i(abort_i),
        .fifo_empty_i(fifo_empty_i), .fifo_data_i(fifo_data_i), .fifo_pop_o(fifo_pop_o),
        .fifo_flush_o(fifo_flush_o), .tx_valid_o(tx_valid_o), .tx_data_o(tx_data_o),
        .tx_last_o(tx_last_o), .tx_accept_i(tx_accept_i), .busy_o(busy_o), .done_o(done_o),
        .underrun_o(underrun_o), .remaining_o(remaining_o)
    );

    always #5 clk_i = ~clk_i;

    assign fifo_empty_i = (head == tail);
    assign fifo_data_i  = mem[head[7:0]];

    always @(posedge clk_i) begin
        if (fifo_flush_o) head <= tail;
        else if (fifo_pop_o) head <= head + 1;
    end

    always @(negedge clk_i) begin
        if (n_rst_i) begin
            if (tx_valid_o && tx_accept_i && !abort_i) begin
                obs_d.push_back(tx_data_o);
                obs_l.push_back(tx_last_o);
            end
            pops    <= pops + int'(fifo_pop_o);
            dones   <= dones + int'(done_o);
            unders  <= unders + int'(underrun_o);
            flushes <= flushes + int'(fifo_flush_o);
        end
    end

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk_i);
            #1;
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[tail[7:0]] = b;
        tail++;
    endtask

    task automatic test_reset();
        #12;
        cmp++;
        if ({tx_valid_o, tx_last_o, busy_o, done_o, underrun_o, fifo_flush_o, fifo_pop_o} !== 7'b0) begin
            errs++;
            $display("FAIL reset_flags got %b want 0000000",
                     {tx_valid_o, tx_last_o, busy_o, done_o, underrun_o, fifo_flush_o, fifo_pop_o});
        end
        cmp++;
        if (tx_data_o !== 8'h00 || remaining_o !== '0) begin
            errs++;
            $display("FAIL reset_data got data=%h rem=%0d want 0/0", tx_data_o, remaining_o);
        end
        @(negedge clk_i);
        n_rst_i = 1'b1;
        step(2);
        cmp++;
        if (busy_o !== 1'b0 || tx_valid_o !== 1'b0) begin
            errs++;
            $display("FAIL reset_idle got busy=%b valid=%b want 0/0", busy_o, tx_valid_o);
        end
    endtask

    task automatic test_single();
        logic [7:0] b [3];
        int p0, d0;
        b[0] = 8'h11; b[1] = 8'h22; b[2] = 8'h33;
        for (int i = 0; i < 3; i++) push(b[i]);
        p0 = pops; d0 = dones;
        tx_accept_i = 1'b1;
        start_i = 1'b1; len_i = LEN_W'(3);
        step();
        start_i = 1'b0;
        @(negedge clk_i);
        cmp++;
        if (busy_o !== 1'b1 || tx_valid_o !== 1'b0 || fifo_pop_o !== 1'b1) begin
            errs++;
            $display("FAIL single_load got busy=%b valid=%b pop=%b want 1/0/1", busy_o, tx_valid_o, fifo_pop_o);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            cmp++;
            if (tx_valid_o !== 1'b1 || tx_data_o !== b[i] || tx_last_o !== (i == 2)) begin
                errs++;
                $display("FAIL single_byte%0d got v=%b d=%h l=%b want 1/%h/%b",
                         i, tx_valid_o, tx_data_o, tx_last_o, b[i], i == 2);
            end
        end
        @(negedge clk_i);
        cmp++;
        if (done_o !== 1'b1 || tx_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            errs++;
            $display("FAIL single_done got done=%b valid=%b busy=%b want 1/0/0", done_o, tx_valid_o, busy_o);
        end
        step();
        tx_accept_i = 1'b0;
        cmp++;
        if (pops - p0 !== 3 || dones - d0 !== 1) begin
            errs++;
            $display("FAIL single_counts got pops=%0d dones=%0d want 3/1", pops - p0, dones - d0);
        end
    endtask

    task automatic test_zero_len();
        int p0, d0;
        p0 = pops; d0 = dones;
        start_i = 1'b1; len_i = '0;
        step();
        start_i = 1'b0;
        @(negedge clk_i);
        cmp++;
        if (done_o !== 1'b1 || busy_o !== 1'b0) begin
            errs++;
            $display("FAIL zero_done got done=%b busy=%b want 1/0", done_o, busy_o);
        end
        step(3);
        cmp++;
        if (pops - p0 !== 0 || dones - d0 !== 1 || busy_o !== 1'b0) begin
            errs++;
            $display("FAIL zero_counts got pops=%0d dones=%0d busy=%b want 0/1/0", pops - p0, dones - d0, busy_o);
        end
    endtask

    task automatic test_refill();
        logic [7:0] b [4];
        int p0, d0, u0, base, d, low, t;
        for (int i = 0; i < 4; i++) b[i] = 8'($urandom);
        push(b[0]); push(b[1]);
        p0 = pops; d0 = dones; u0 = unders; base = obs_d.size();
        tx_accept_i = 1'b1;
        start_i = 1'b1; len_i = LEN_W'(4);
        step();
        start_i = 1'b0;
        d = $urandom_range(5, 9);
        low = 0;
        repeat (d) begin
            @(negedge clk_i);
            if (busy_o && !tx_valid_o) low++;
            @(posedge clk_i);
            #1;
        end
        push(b[2]); push(b[3]);
        t = 0;
        while (dones == d0 && t < 50) begin
            step();
            t++;
        end
        tx_accept_i = 1'b0;
        cmp++;
        if (t >= 50) begin
            errs++;
            $display("FAIL refill_timeout got no done within %0d cycles want done", t);
        end
        cmp++;
        if (obs_d.size() - base !== 4) begin
            errs++;
            $display("FAIL refill_count got %0d bytes want 4", obs_d.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                cmp++;
                if (obs_d[base+i] !== b[i] || obs_l[base+i] !== (i == 3)) begin
                    errs++;
                    $display("FAIL refill_byte%0d got %h/%b want %h/%b", i, obs_d[base+i], obs_l[base+i], b[i], i == 3);
                end
            end
        end
        cmp++;
        if (low < 3 || unders - u0 !== 0 || pops - p0 !== 4) begin
            errs++;
            $display("FAIL refill_gap got lowcycles=%0d underruns=%0d pops=%0d want >=3/0/4", low, unders - u0, pops - p0);
        end
    endtask

    task automatic test_underrun();
        int len;
        len = $urandom_range(1, 255);
        tx_accept_i = 1'b1;
        start_i = 1'b1; len_i = LEN_W'(len);
        step();
        start_i = 1'b0;
        for (int k = 0; k < TO; k++) begin
            @(negedge clk_i);
            cmp++;
            if (underrun_o !== 1'b0 || busy_o !== 1'b1 || fifo_pop_o !== 1'b0 ||
                (k == 0 && remaining_o !== LEN_W'(len))) begin
                errs++;
                $display("FAIL underrun_wait%0d got u=%b busy=%b pop=%b rem=%0d want 0/1/0/%0d",
                         k, underrun_o, busy_o, fifo_pop_o, remaining_o, len);
            end
        end
        @(negedge clk_i);
        cmp++;
        if (underrun_o !== 1'b1 || fifo_flush_o !== 1'b1 || busy_o !== 1'b0 || remaining_o !== '0 || done_o !== 1'b0) begin
            errs++;
            $display("FAIL underrun_pulse got u=%b fl=%b busy=%b rem=%0d done=%b want 1/1/0/0/0",
                     underrun_o, fifo_flush_o, busy_o, remaining_o, done_o);
        end
        @(negedge clk_i);
        cmp++;
        if (underrun_o !== 1'b0 || fifo_flush_o !== 1'b0) begin
            errs++;
            $display("FAIL underrun_once got u=%b fl=%b want 0/0", underrun_o, fifo_flush_o);
        end
        step();
        tx_accept_i = 1'b0;
    endtask

    task automatic test_abort();
        logic [7:0] b [5];
        int d0, f0, base;
        for (int i = 0; i < 5; i++) begin
            b[i] = 8'($urandom);
            push(b[i]);
        end
        d0 = dones; f0 = flushes; base = obs_d.size();
        start_i = 1'b1; len_i = LEN_W'(5);
        step();
        start_i = 1'b0;
        step();
        tx_accept_i = 1'b1;
        step();
        tx_accept_i = 1'b0;
        repeat (6) begin
            @(negedge clk_i);
            cmp++;
            if (tx_valid_o !== 1'b1 || tx_data_o !== b[1] || tx_last_o !== 1'b0) begin
                errs++;
                $display("FAIL abort_stall got v=%b d=%h l=%b want 1/%h/0", tx_valid_o, tx_data_o, tx_last_o, b[1]);
            end
        end
        @(posedge clk_i);
        #1;
        abort_i = 1'b1; tx_accept_i = 1'b1;
        @(negedge clk_i);
        cmp++;
        if (fifo_pop_o !== 1'b0) begin
            errs++;
            $display("FAIL abort_nopop got pop=%b want 0", fifo_pop_o);
        end
        @(posedge clk_i);
        #1;
        abort_i = 1'b0; tx_accept_i = 1'b0;
        @(negedge clk_i);
        cmp++;
        if ({tx_valid_o, tx_last_o, fifo_flush_o, busy_o, done_o, underrun_o} !== 6'b001000 || remaining_o !== '0) begin
            errs++;
            $display("FAIL abort_after got v/l/fl/busy/done/u=%b rem=%0d want 001000/0",
                     {tx_valid_o, tx_last_o, fifo_flush_o, busy_o, done_o, underrun_o}, remaining_o);
        end
        @(negedge clk_i);
        cmp++;
        if (fifo_flush_o !== 1'b0) begin
            errs++;
            $display("FAIL abort_flush_once got fl=%b want 0", fifo_flush_o);
        end
        step();
        cmp++;
        if (dones - d0 !== 0 || flushes - f0 !== 1 || fifo_empty_i !== 1'b1 || obs_d.size() - base !== 1) begin
            errs++;
            $display("FAIL abort_counts got dones=%0d flushes=%0d empty=%b sent=%0d want 0/1/1/1",
                     dones - d0, flushes - f0, fifo_empty_i, obs_d.size() - base);
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            logic [7:0] exp [$];
            int len, ap, pre, pushed, gap, t, p0, d0, u0, base, bad;
            len = $urandom_range(1, 20);
            ap = $urandom_range(30, 100);
            exp.delete();
            for (int i = 0; i < len; i++) exp.push_back(8'($urandom));
            p0 = pops; d0 = dones; u0 = unders; base = obs_d.size();
            pre = $urandom_range(0, len);
            for (pushed = 0; pushed < pre; pushed++) push(exp[pushed]);
            start_i = 1'b1; len_i = LEN_W'(len);
            step();
            start_i = 1'b0;
            gap = 0; t = 0;
            while (dones == d0 && t < 400) begin
                tx_accept_i = ($urandom_range(1, 100) <= ap);
                if (pushed < len && (gap >= 3 || $urandom_range(0, 1) == 1)) begin
                    push(exp[pushed]);
                    pushed++;
                    gap = 0;
                end else begin
                    gap++;
                end
                step();
                t++;
            end
            tx_accept_i = 1'b0;
            step();
            cmp++;
            if (t >= 400 || dones - d0 !== 1 || unders - u0 !== 0 || pops - p0 !== len) begin
                errs++;
                $display("FAIL random%0d_counts got cycles=%0d dones=%0d underruns=%0d pops=%0d want <400/1/0/%0d",
                         n, t, dones - d0, unders - u0, pops - p0, len);
            end
            cmp++;
            if (obs_d.size() - base !== len) begin
                errs++;
                $display("FAIL random%0d_len got %0d bytes want %0d", n, obs_d.size() - base, len);
            end else begin
                bad = 0;
                for (int i = 0; i < len; i++)
                    if (obs_d[base+i] !== exp[i] || obs_l[base+i] !== (i == len - 1)) bad++;
                cmp++;
                if (bad != 0) begin
                    errs++;
                    $display("FAIL random%0d_data got %0d wrong bytes/last flags want 0", n, bad);
                end
            end
            cmp++;
            if (remaining_o !== '0 || busy_o !== 1'b0 || fifo_empty_i !== 1'b1) begin
                errs++;
                $display("FAIL random%0d_end got rem=%0d busy=%b empty=%b want 0/0/1", n, remaining_o, busy_o, fifo_empty_i);
            end
        end
    endtask

    task automatic test_max_len();
        logic [7:0] exp [$];
        int d0, base, t, bad, prev, mono;
        exp.delete();
        for (int i = 0; i < 255; i++) begin
            exp.push_back(8'($urandom));
            push(exp[i]);
        end
        d0 = dones; base = obs_d.size();
        tx_accept_i = 1'b1;
        start_i = 1'b1; len_i = '1;
        step();
        start_i = 1'b0;
        @(negedge clk_i);
        cmp++;
        if (remaining_o !== LEN_W'(255)) begin
            errs++;
            $display("FAIL max_start got rem=%0d want 255", remaining_o);
        end
        @(posedge clk_i);
        #1;
        prev = 255; mono = 1; t = 0;
        while (dones == d0 && t < 400) begin
            @(negedge clk_i);
            if (int'(remaining_o) > prev) mono = 0;
            prev = int'(remaining_o);
            @(posedge clk_i);
            #1;
            t++;
        end
        tx_accept_i = 1'b0;
        cmp++;
        if (t >= 400 || mono != 1 || remaining_o !== '0) begin
            errs++;
            $display("FAIL max_progress got cycles=%0d monotonic=%0d rem=%0d want <400/1/0", t, mono, remaining_o);
        end
        cmp++;
        if (obs_d.size() - base !== 255) begin
            errs++;
            $display("FAIL max_len got %0d bytes want 255", obs_d.size() - base);
        end else begin
            bad = 0;
            for (int i = 0; i < 255; i++)
                if (obs_d[base+i] !== exp[i] || obs_l[base+i] !== (i == 254)) bad++;
            cmp++;
            if (bad != 0) begin
                errs++;
                $display("FAIL max_data got %0d wrong bytes/last flags want 0", bad);
            end
        end
    endtask

    task automatic test_async_reset();
        int f0;
        for (int i = 0; i < 3; i++) push(8'($urandom));
        f0 = flushes;
        start_i = 1'b1; len_i = LEN_W'(3);
        step();
        start_i = 1'b0;
        step();
        start_i = 1'b1; len_i = LEN_W'(7);
        step(2);
        start_i = 1'b0;
        cmp++;
        if (remaining_o !== LEN_W'(2) || busy_o !== 1'b1 || tx_valid_o !== 1'b1) begin
            errs++;
            $display("FAIL busy_start got rem=%0d busy=%b valid=%b want 2/1/1", remaining_o, busy_o, tx_valid_o);
        end
        @(negedge clk_i);
        #2;
        n_rst_i = 1'b0;
        #1;
        cmp++;
        if ({tx_valid_o, tx_last_o, busy_o, done_o, underrun_o, fifo_flush_o, fifo_pop_o} !== 7'b0 ||
            tx_data_o !== 8'h00 || remaining_o !== '0) begin
            errs++;
            $display("FAIL async_reset got flags=%b data=%h rem=%0d want 0000000/00/0",
                     {tx_valid_o, tx_last_o, busy_o, done_o, underrun_o, fifo_flush_o, fifo_pop_o}, tx_data_o, remaining_o);
        end
        @(negedge clk_i);
        n_rst_i = 1'b1;
        step();
        cmp++;
        if (fifo_empty_i !== 1'b0 || flushes - f0 !== 0) begin
            errs++;
            $display("FAIL reset_noflush got empty=%b flushes=%0d want 0/0", fifo_empty_i, flushes - f0);
        end
        abort_i = 1'b1;
        step();
        abort_i = 1'b0;
        @(negedge clk_i);
        cmp++;
        if (fifo_flush_o !== 1'b1 || busy_o !== 1'b0 || done_o !== 1'b0) begin
            errs++;
            $display("FAIL idle_abort got fl=%b busy=%b done=%b want 1/0/0", fifo_flush_o, busy_o, done_o);
        end
        step();
        cmp++;
        if (fifo_empty_i !== 1'b1) begin
            errs++;
            $display("FAIL idle_abort_flush got empty=%b want 1", fifo_empty_i);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got no finish want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single();
        test_zero_len();
        test_refill();
        test_underrun();
        test_abort();
        test_random();
        test_max_len();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule
